rr_mem_initiator: RTL and testbench

Avalon-MM initiator for the `rr` system's single-port on-chip RAM (32-bit words, 14-bit word address, fixed 1-cycle read latency, no waitrequest). It accepts block commands on a valid/ready port and runs them against the RAM. FILL writes an incrementing pattern. READ streams words out on a back-pressured valid/ready port and accumulates a checksum. It sits between a control agent (CPU bridge or test sequencer) and the RAM's slave port.

---
 rtl/rr_mem_init_pkg.sv | 20 ++
 rtl/rr_mem_init_rdbuf.sv | 43 ++++
 rtl/rr_mem_initiator.sv | 147 ++++++++++++++
 tb/tb_rr_mem_initiator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mem_init_pkg.sv
// Shared types and default geometry for the rr on-chip RAM initiator.
package rr_mem_init_pkg;

  localparam int MEM_DEPTH = 10240;
  localparam int MEM_AW    = 14;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_READ = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rr_mem_init_rdbuf.sv
// Two-entry read-return FIFO feeding the rd_valid/rd_data stream.
// Push and pop in the same cycle on a full buffer is legal: the slot being
// overwritten is the head that is leaving this cycle.
module rr_mem_init_rdbuf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [1:0]  count,
  output logic        valid,
  output logic [31:0] data
);

  logic [1:0][31:0] mem;
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage, pointers and occupancy; everything clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != 2'd0);
  assign data  = mem[rd_ptr];

endmodule

// File: rtl/rr_mem_initiator.sv
// Avalon-MM block initiator for the rr single-port RAM: FILL writes an
// incrementing pattern, READ streams words out with back-pressure.
// Optional: define RR_MEM_INIT_CHECKSUM_EN to build the READ checksum
// accumulator; otherwise done_sum is tied to 0.
module rr_mem_initiator
  import rr_mem_init_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = MEM_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [31:0]   cmd_data,
  output logic          avm_chipselect,
  output logic          avm_write,
  output logic [AW-1:0] avm_address,
  output logic [3:0]    avm_byteenable,
  output logic [31:0]   avm_writedata,
  input  logic [31:0]   avm_readdata,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [31:0]   rd_data,
  output logic          done,
  output logic          done_err,
  output logic [31:0]   done_sum
);

  state_e        state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] rem_q;
  logic [31:0]   pat_q;
  logic          err_q;
  logic          inflight_q;
  logic [1:0]    buf_cnt;
  logic          buf_pop;
  logic          issue;
  logic          cmd_bad;
  logic          cmd_take;
  logic [AW-1:0] addr_inc;
  logic [2:0]    occ;

  assign cmd_take = (state == ST_IDLE) && cmd_valid;
  assign cmd_bad  = ({1'b0, cmd_addr} >= (AW+1)'(DEPTH)) ||
                    ({1'b0, cmd_len}  >  (AW+1)'(DEPTH));
  assign addr_inc = (addr_q == AW'(DEPTH-1)) ? '0 : addr_q + AW'(1);

  // A read may issue only if the buffer can still absorb every word that is
  // already owed to it once this cycle's pop has happened.
  assign buf_pop = rd_valid && rd_ready;
  assign occ     = {1'b0, buf_cnt} + {2'b0, inflight_q};
  assign issue   = (state == ST_READ) && ((occ - {2'b0, buf_pop}) < 3'd2);

  rr_mem_init_rdbuf u_rdbuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (avm_readdata),
    .pop       (buf_pop),
    .count     (buf_cnt),
    .valid     (rd_valid),
    .data      (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; DRAIN looks ahead so DONE lands right after the last pop.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad || (cmd_len == '0)) state_nxt = ST_DONE;
          else if (op_e'(cmd_op) == OP_READ) state_nxt = ST_READ;
          else state_nxt = ST_FILL;
        end
      end
      ST_FILL:  if (rem_q == AW'(1)) state_nxt = ST_DONE;
      ST_READ:  if (issue && (rem_q == AW'(1))) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!inflight_q && ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && buf_pop)))
          state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, address/pattern/remaining counters and the 1-cycle read tracker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      pat_q      <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (cmd_take) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
        pat_q  <= cmd_data;
        err_q  <= cmd_bad;
      end else if ((state == ST_FILL) || issue) begin
        addr_q <= addr_inc;
        rem_q  <= rem_q - AW'(1);
        pat_q  <= pat_q + 32'd1;
      end
    end
  end

`ifdef RR_MEM_INIT_CHECKSUM_EN
  logic [31:0] sum_q;

  // Running sum of every returned read word; cleared when a command is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        sum_q <= '0;
    else if (cmd_take)   sum_q <= '0;
    else if (inflight_q) sum_q <= sum_q + avm_readdata;
  end

  assign done_sum = (state == ST_DONE) ? sum_q : '0;
`else
  assign done_sum = '0;
`endif

  // Output decode; cmd_ready is held low while reset is asserted.
  always_comb begin
    cmd_ready      = (state == ST_IDLE) && reset_n;
    avm_chipselect = (state == ST_FILL) || issue;
    avm_write      = (state == ST_FILL);
    avm_address    = avm_chipselect ? addr_q : '0;
    avm_byteenable = avm_chipselect ? 4'hF : 4'h0;
    avm_writedata  = (state == ST_FILL) ? pat_q : '0;
    done           = (state == ST_DONE);
    done_err       = (state == ST_DONE) && err_q;
  end

endmodule

// File: tb/tb_rr_mem_initiator.sv
// Scoreboard bench for rr_mem_initiator with a 1-cycle-latency RAM model.
`timescale 1ns/1ps
module tb_rr_mem_initiator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid, cmd_op;
  logic [13:0] cmd_addr, cmd_len;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        avm_chipselect, avm_write;
  logic [13:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata, avm_readdata;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic [31:0] done_sum;

  rr_mem_initiator #(.DEPTH(10240), .AW(14)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .done_err(done_err), .done_sum(done_sum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // RAM model: zeroed once during the first reset, 1-cycle read latency.
  logic [31:0] ram [0:16383];
  bit ram_clr = 1'b0;
  int acc_cnt = 0;
  always @(posedge clk) begin
    if (!ram_clr) begin
      for (int i = 0; i < 16384; i++) ram[i] <= '0;
      ram_clr <= 1'b1;
    end else if (avm_chipselect) begin
      acc_cnt++;
      if (avm_write) ram[avm_address] <= avm_writedata;
      else           avm_readdata <= ram[avm_address];
    end
  end

  // rd_ready driver: mode 0 = always ready, mode 1 = repeating 1-0-0-1.
  int rd_mode = 0;
  int ph = 0;
  logic [3:0] tog = 4'b1001;
  always @(posedge clk) begin
    #1;
    if (rd_mode == 1) begin
      rd_ready = tog[ph];
      ph = (ph + 1) % 4;
    end else begin
      rd_ready = 1'b1;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] sum;
    int          lat;
  } done_t;

  logic [31:0] exp_rd_q[$];
  done_t       exp_done_q[$];
  int acc_cyc = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int out_cnt = 0;
  int max_out = 0;
  bit hold_prev = 1'b0;
  logic [31:0] hold_data;

  function automatic logic [31:0] es(input logic [31:0] v);
`ifdef RR_MEM_INIT_CHECKSUM_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents data or done.
  always @(negedge clk) begin
    logic [31:0] e;
    done_t d;
    if (!reset_n) begin
      out_cnt   = 0;
      hold_prev = 1'b0;
    end else begin
      if (out_cnt > max_out) max_out = out_cnt;
      if (hold_prev && rd_valid) begin
        tests++;
        if (rd_data !== hold_data) begin
          fails++;
          $display("FAIL rd_hold: got %h expected %h", rd_data, hold_data);
        end
      end
      hold_prev = rd_valid && !rd_ready;
      hold_data = rd_data;
      if (rd_valid && rd_ready) begin
        tests++;
        if (exp_rd_q.size() == 0) begin
          fails++;
          $display("FAIL rd_data: got unexpected word %h expected none", rd_data);
        end else begin
          e = exp_rd_q.pop_front();
          if (rd_data !== e) begin
            fails++;
            $display("FAIL rd_data: got %h expected %h", rd_data, e);
          end
        end
        pop_cnt++;
      end
      out_cnt = out_cnt + ((avm_chipselect && !avm_write) ? 1 : 0)
                        - ((rd_valid && rd_ready) ? 1 : 0);
      if (done) begin
        done_cnt++;
        tests++;
        if (exp_done_q.size() == 0) begin
          fails++;
          $display("FAIL done: got unexpected pulse expected none");
        end else begin
          d = exp_done_q.pop_front();
          if (done_err !== d.err || done_sum !== d.sum ||
              (d.lat >= 0 && (cyc - acc_cyc) != d.lat)) begin
            fails++;
            $display("FAIL done: got err=%0b sum=%h lat=%0d expected err=%0b sum=%h lat=%0d",
                     done_err, done_sum, cyc - acc_cyc, d.err, d.sum, d.lat);
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic op, input logic [13:0] a, input logic [13:0] l,
                          input logic [31:0] dat);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l; cmd_data = dat;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
  endtask

  task automatic push_done(input logic err, input logic [31:0] sum, input int lat);
    done_t d;
    d.err = err; d.sum = sum; d.lat = lat;
    exp_done_q.push_back(d);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_avm"}, {12'd0, avm_chipselect, avm_write, avm_address, avm_byteenable,
                        avm_writedata}, 64'd0);
    chk({tag, "_rd"}, {31'd0, rd_valid, rd_data}, 64'd0);
    chk({tag, "_done"}, {30'd0, done, done_err, done_sum}, 64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
  endtask

  initial begin
    int a0;
    int n;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_data = '0;

    // Reset state and release
    #23;
    chk_quiet("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("release_cmd_ready", 64'(cmd_ready), 64'd1);

    // FILL 0x10 x4 from 0xA0
    push_done(1'b0, 32'd0, 4);
    send_cmd(1'b0, 14'h10, 14'd4, 32'hA0);
    wait_done(1);
    for (int i = 0; i < 4; i++) chk("fill_ram", 64'(ram[16 + i]), 64'(32'hA0 + i));
    chk("fill_ram_untouched", 64'(ram[20]), 64'd0);

    // READ back, always ready
    for (int i = 0; i < 4; i++) exp_rd_q.push_back(32'hA0 + i);
    push_done(1'b0, es(32'h286), 6);
    send_cmd(1'b1, 14'h10, 14'd4, 32'd0);
    wait_done(2);
    chk("read_drained", 64'(exp_rd_q.size()), 64'd0);

    // FILL across the wrap point
    push_done(1'b0, 32'd0, 4);
    send_cmd(1'b0, 14'd10238, 14'd4, 32'h55);
    wait_done(3);
    chk("wrap_10238", 64'(ram[10238]), 64'h55);
    chk("wrap_10239", 64'(ram[10239]), 64'h56);
    chk("wrap_0", 64'(ram[0]), 64'h57);
    chk("wrap_1", 64'(ram[1]), 64'h58);
    chk("wrap_2_untouched", 64'(ram[2]), 64'd0);

    // READ len 6 across the wrap with 1-0-0-1 back-pressure
    rd_mode = 1;
    exp_rd_q.push_back(32'h55); exp_rd_q.push_back(32'h56);
    exp_rd_q.push_back(32'h57); exp_rd_q.push_back(32'h58);
    exp_rd_q.push_back(32'h0);  exp_rd_q.push_back(32'h0);
    push_done(1'b0, es(32'h15A), -1);
    send_cmd(1'b1, 14'd10238, 14'd6, 32'd0);
    wait_done(4);
    rd_mode = 0;
    chk("bp_drained", 64'(exp_rd_q.size()), 64'd0);
    chk("max_outstanding_le2", 64'(max_out <= 2), 64'd1);

    // Rejected commands: bad address, over-long length
    a0 = acc_cnt;
    push_done(1'b1, 32'd0, 0);
    send_cmd(1'b0, 14'd10240, 14'd1, 32'd0);
    wait_done(5);
    push_done(1'b1, 32'd0, 0);
    send_cmd(1'b1, 14'd0, 14'd10241, 32'd0);
    wait_done(6);
    chk("err_no_access", 64'(acc_cnt - a0), 64'd0);

    // No-op
    a0 = acc_cnt;
    push_done(1'b0, 32'd0, 0);
    send_cmd(1'b0, 14'd5, 14'd0, 32'd0);
    wait_done(7);
    chk("noop_no_access", 64'(acc_cnt - a0), 64'd0);

    // Reset in the middle of a READ once two words are out
    for (int i = 0; i < 4; i++) exp_rd_q.push_back(32'hA0 + i);
    a0 = pop_cnt;
    send_cmd(1'b1, 14'h10, 14'd4, 32'd0);
    n = 0;
    while (pop_cnt < a0 + 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("midreset_two_popped", 64'(pop_cnt - a0), 64'd2);
    #3;
    reset_n = 1'b0;
    #1;
    chk_quiet("midreset");
    exp_rd_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midreset_release_ready", 64'(cmd_ready), 64'd1);
    repeat (6) @(posedge clk);
    chk("midreset_no_done", 64'(done_cnt), 64'd7);

    // Normal FILL after the reset
    push_done(1'b0, 32'd0, 2);
    send_cmd(1'b0, 14'h20, 14'd2, 32'h7);
    wait_done(8);
    chk("post_reset_fill0", 64'(ram[32]), 64'h7);
    chk("post_reset_fill1", 64'(ram[33]), 64'h8);

    repeat (3) @(posedge clk);
    chk("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
